// File: rtl/ptp_local_clock.sv
// ptp_local_clock: free-running 80-bit PTP time-of-day counter with a
// trimmed per-cycle increment, hard time load, seconds pulse and sync flag.
module ptp_local_clock #(
  parameter logic [31:0] NOMINAL_INC_NS = 32'd4,
  parameter logic [31:0] NS_PER_SEC     = 32'd1_000_000_000,
  parameter logic [31:0] MAX_ADJ        = 32'h0100_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [79:0] i_clock_add_gap,
  input  logic        i_clock_add_gap_sign,
  input  logic        i_clock_add_gap_valid,
  input  logic [79:0] i_time_set,
  input  logic        i_time_set_valid,
  output logic [79:0] o_local_time,
  output logic [31:0] o_local_frac,
  output logic        o_pps,
  output logic        o_synced,
  output logic        o_adj_clamped
);

  localparam logic [63:0] NOMINAL_INC = {NOMINAL_INC_NS, 32'h0};

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [47:0] sec;
  logic [31:0] ns;
  logic [31:0] frac;
  logic        pps;
  logic        clamped;
  logic [63:0] inc;

  logic        gap_clamp;
  logic [31:0] trim;
  logic [63:0] inc_new;

  logic [64:0] sum;
  logic [32:0] sum_ns;
  logic        rollover;
  logic [31:0] ns_wrapped;

  // Gap decode: an out-of-range gap (upper bits set or above MAX_ADJ)
  // saturates to MAX_ADJ and is flagged.
  always_comb begin
    gap_clamp = (i_clock_add_gap[79:32] != '0) || (i_clock_add_gap[31:0] > MAX_ADJ);
    trim      = gap_clamp ? MAX_ADJ : i_clock_add_gap[31:0];
    inc_new   = i_clock_add_gap_sign ? (NOMINAL_INC - {32'h0, trim})
                                     : (NOMINAL_INC + {32'h0, trim});
  end

  // Next-time computation: 65-bit add of {ns, frac} and inc, then ns rollover.
  always_comb begin
    sum        = {1'b0, ns, frac} + {1'b0, inc};
    sum_ns     = sum[64:32];
    rollover   = (sum_ns >= {1'b0, NS_PER_SEC});
    ns_wrapped = sum_ns[31:0] - NS_PER_SEC;
  end

  // Sync state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= UNSYNC;
    else        state <= state_nxt;
  end

  // Sync next-state: any accepted load enters SYNC; only reset leaves it.
  always_comb begin
    state_nxt = state;
    if (i_time_set_valid) state_nxt = SYNC;
  end

  // Increment register and sticky clamp flag; each gap replaces the last.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      inc     <= NOMINAL_INC;
      clamped <= 1'b0;
    end else if (i_clock_add_gap_valid) begin
      inc     <= inc_new;
      clamped <= clamped | gap_clamp;
    end
  end

  // Time accumulator: a load overrides the increment for that cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sec  <= '0;
      ns   <= '0;
      frac <= '0;
      pps  <= 1'b0;
    end else if (i_time_set_valid) begin
      sec  <= i_time_set[79:32];
      ns   <= i_time_set[31:0];
      frac <= '0;
      pps  <= 1'b0;
    end else if (rollover) begin
      sec  <= sec + 48'd1;
      ns   <= ns_wrapped;
      frac <= sum[31:0];
      pps  <= 1'b1;
    end else begin
      ns   <= sum[63:32];
      frac <= sum[31:0];
      pps  <= 1'b0;
    end
  end

  assign o_local_time  = {sec, ns};
  assign o_local_frac  = frac;
  assign o_pps         = pps;
  assign o_synced      = (state == SYNC);
  assign o_adj_clamped = clamped;

endmodule

// File: tb/tb_ptp_local_clock.sv
// Directed self-checking bench for ptp_local_clock (MAX_ADJ = 0x8000_0000).
module tb_ptp_local_clock;

  logic        clk;
  logic        rst;
  logic [79:0] gap;
  logic        gap_sign;
  logic        gap_valid;
  logic [79:0] tset;
  logic        tset_valid;
  logic [79:0] local_time;
  logic [31:0] local_frac;
  logic        pps;
  logic        synced;
  logic        adj_clamped;

  int unsigned errors;
  int unsigned checks;

  ptp_local_clock #(
    .NOMINAL_INC_NS(32'd4),
    .NS_PER_SEC    (32'd1_000_000_000),
    .MAX_ADJ       (32'h8000_0000)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_clock_add_gap      (gap),
    .i_clock_add_gap_sign (gap_sign),
    .i_clock_add_gap_valid(gap_valid),
    .i_time_set           (tset),
    .i_time_set_valid     (tset_valid),
    .o_local_time         (local_time),
    .o_local_frac         (local_frac),
    .o_pps                (pps),
    .o_synced             (synced),
    .o_adj_clamped        (adj_clamped)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic test_reset();
    logic pps_seen;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (local_time !== 80'd0 || local_frac !== 32'd0 || pps !== 1'b0 ||
        synced !== 1'b0 || adj_clamped !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: time=%h frac=%h pps=%b synced=%b clamped=%b expected all zero",
               local_time, local_frac, pps, synced, adj_clamped);
    end
    rst = 1'b1;
    pps_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pps) pps_seen = 1'b1;
    end
    checks++;
    if (local_time !== {48'd0, 32'd40}) begin
      errors++;
      $display("FAIL reset_count: got %h expected %h", local_time, {48'd0, 32'd40});
    end
    checks++;
    if (synced !== 1'b0 || pps_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: synced=%b pps_seen=%b expected 0 0", synced, pps_seen);
    end
  endtask

  task automatic test_rollover();
    tset = {48'd5, 32'd999_999_996};
    tset_valid = 1'b1;
    @(negedge clk);
    tset_valid = 1'b0;
    checks++;
    if (local_time !== {48'd5, 32'd999_999_996} || pps !== 1'b0 || synced !== 1'b1) begin
      errors++;
      $display("FAIL load: time=%h pps=%b synced=%b expected %h 0 1",
               local_time, pps, synced, {48'd5, 32'd999_999_996});
    end
    @(negedge clk);
    checks++;
    if (local_time !== {48'd6, 32'd0} || pps !== 1'b1 || local_frac !== 32'd0) begin
      errors++;
      $display("FAIL rollover: time=%h pps=%b frac=%h expected %h 1 0",
               local_time, pps, local_frac, {48'd6, 32'd0});
    end
    @(negedge clk);
    checks++;
    if (local_time !== {48'd6, 32'd4} || pps !== 1'b0) begin
      errors++;
      $display("FAIL pps_one_cycle: time=%h pps=%b expected %h 0",
               local_time, pps, {48'd6, 32'd4});
    end
  endtask

  task automatic test_pos_trim();
    gap = 80'h8000_0000;
    gap_sign = 1'b0;
    gap_valid = 1'b1;
    @(negedge clk);
    gap_valid = 1'b0;
    tset = 80'd0;
    tset_valid = 1'b1;
    @(negedge clk);
    tset_valid = 1'b0;
    checks++;
    if (local_time !== 80'd0 || local_frac !== 32'd0) begin
      errors++;
      $display("FAIL pos_trim_load: time=%h frac=%h expected 0 0", local_time, local_frac);
    end
    @(negedge clk);
    checks++;
    if (local_time !== {48'd0, 32'd4} || local_frac !== 32'h8000_0000) begin
      errors++;
      $display("FAIL pos_trim_step1: time=%h frac=%h expected %h 80000000",
               local_time, local_frac, {48'd0, 32'd4});
    end
    @(negedge clk);
    checks++;
    if (local_time !== {48'd0, 32'd9} || local_frac !== 32'd0 || adj_clamped !== 1'b0) begin
      errors++;
      $display("FAIL pos_trim_step2: time=%h frac=%h clamped=%b expected %h 0 0",
               local_time, local_frac, adj_clamped, {48'd0, 32'd9});
    end
  endtask

  task automatic test_neg_trim_clamp();
    gap = 80'h4000_0000;
    gap_sign = 1'b1;
    gap_valid = 1'b1;
    @(negedge clk);
    gap_valid = 1'b0;
    tset = {48'd1, 32'd0};
    tset_valid = 1'b1;
    @(negedge clk);
    tset_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (local_time !== {48'd1, 32'd3} || local_frac !== 32'hC000_0000) begin
      errors++;
      $display("FAIL neg_trim_step1: time=%h frac=%h expected %h c0000000",
               local_time, local_frac, {48'd1, 32'd3});
    end
    @(negedge clk);
    checks++;
    if (local_time !== {48'd1, 32'd7} || local_frac !== 32'h8000_0000 || adj_clamped !== 1'b0) begin
      errors++;
      $display("FAIL neg_trim_step2: time=%h frac=%h clamped=%b expected %h 80000000 0",
               local_time, local_frac, adj_clamped, {48'd1, 32'd7});
    end
    // Oversize gap: upper bits set, saturates to MAX_ADJ -> step 3.5 ns.
    gap = 80'h1_0000_0000;
    gap_sign = 1'b1;
    gap_valid = 1'b1;
    @(negedge clk);
    gap_valid = 1'b0;
    checks++;
    if (local_time !== {48'd1, 32'd11} || local_frac !== 32'h4000_0000 || adj_clamped !== 1'b1) begin
      errors++;
      $display("FAIL clamp_latch: time=%h frac=%h clamped=%b expected %h 40000000 1",
               local_time, local_frac, adj_clamped, {48'd1, 32'd11});
    end
    @(negedge clk);
    checks++;
    if (local_time !== {48'd1, 32'd14} || local_frac !== 32'hC000_0000) begin
      errors++;
      $display("FAIL clamp_step: time=%h frac=%h expected %h c0000000",
               local_time, local_frac, {48'd1, 32'd14});
    end
    // Zero gap replaces the trim (nominal step) while the flag stays set.
    gap = 80'd0;
    gap_sign = 1'b0;
    gap_valid = 1'b1;
    @(negedge clk);
    gap_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (local_time !== {48'd1, 32'd22} || local_frac !== 32'h4000_0000 || adj_clamped !== 1'b1) begin
      errors++;
      $display("FAIL gap_replace_sticky: time=%h frac=%h clamped=%b expected %h 40000000 1",
               local_time, local_frac, adj_clamped, {48'd1, 32'd22});
    end
  endtask

  task automatic test_simultaneous();
    tset = {48'd2, 32'd100};
    tset_valid = 1'b1;
    gap = 80'h8000_0000;
    gap_sign = 1'b0;
    gap_valid = 1'b1;
    @(negedge clk);
    tset_valid = 1'b0;
    gap_valid = 1'b0;
    checks++;
    if (local_time !== {48'd2, 32'd100} || local_frac !== 32'd0) begin
      errors++;
      $display("FAIL simul_load: time=%h frac=%h expected %h 0",
               local_time, local_frac, {48'd2, 32'd100});
    end
    @(negedge clk);
    checks++;
    if (local_time !== {48'd2, 32'd104} || local_frac !== 32'h8000_0000) begin
      errors++;
      $display("FAIL simul_step1: time=%h frac=%h expected %h 80000000",
               local_time, local_frac, {48'd2, 32'd104});
    end
    @(negedge clk);
    checks++;
    if (local_time !== {48'd2, 32'd109} || local_frac !== 32'd0) begin
      errors++;
      $display("FAIL simul_step2: time=%h frac=%h expected %h 0",
               local_time, local_frac, {48'd2, 32'd109});
    end
  endtask

  task automatic test_midrun_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (local_time !== 80'd0 || local_frac !== 32'd0 || pps !== 1'b0 ||
        synced !== 1'b0 || adj_clamped !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: time=%h frac=%h pps=%b synced=%b clamped=%b expected all zero",
               local_time, local_frac, pps, synced, adj_clamped);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (local_time !== {48'd0, 32'd12} || local_frac !== 32'd0 ||
        synced !== 1'b0 || adj_clamped !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume: time=%h frac=%h synced=%b clamped=%b expected %h 0 0 0",
               local_time, local_frac, synced, adj_clamped, {48'd0, 32'd12});
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b0;
    gap        = '0;
    gap_sign   = 1'b0;
    gap_valid  = 1'b0;
    tset       = '0;
    tset_valid = 1'b0;
    test_reset();
    test_rollover();
    test_pos_trim();
    test_neg_trim_clamp();
    test_simultaneous();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
